// File: rtl/jtdsp16_rsel_pipe.sv
// -----------------------------------------------------------------------------
// jtdsp16_rsel_pipe
//
// Pipelined register-read selector for the JTDSP16 core. It picks one of N
// W-bit register sources and returns the value through PIPE register stages.
// Each result carries a valid flag and can be held by a downstream stall.
// Entries are kept coherent with register write-backs that land while the
// read is still in flight.
//
// Parameters:
//   W     data width of each source
//   N     number of sources (2..8)
//   SELW  width of select fields (2**SELW >= N)
//   PIPE  number of register stages (1 or 2)
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   cen      clock enable; state advances only on clk edges with cen=1
//   src      concatenated sources, source i at bits [i*W +: W]
//   rsel     read source select
//   rd_req   read request, sampled together with rsel
//   stall    downstream hold; no stage advances and rd_req is ignored
//   wr_en    register write-back strobe
//   wr_sel   write-back destination
//   wr_data  write-back data
//   rmux     selected value (last stage register)
//   rvalid   rmux holds a valid read result
//   rsel_q   effective select of the result in rmux
//   fwd      result in rmux came from, or was updated by, wr_data
// -----------------------------------------------------------------------------
module jtdsp16_rsel_pipe #(
  parameter int W    = 16,
  parameter int N    = 4,
  parameter int SELW = 3,
  parameter int PIPE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic [N*W-1:0]    src,
  input  logic [SELW-1:0]   rsel,
  input  logic              rd_req,
  input  logic              stall,
  input  logic              wr_en,
  input  logic [SELW-1:0]   wr_sel,
  input  logic [W-1:0]      wr_data,
  output logic [W-1:0]      rmux,
  output logic              rvalid,
  output logic [SELW-1:0]   rsel_q,
  output logic              fwd
);

  // Out-of-range selects alias to the last source, for reads and writes alike,
  // so a write to an aliased index is seen by a read of the same alias.
  function automatic logic [SELW-1:0] eff_sel(input logic [SELW-1:0] x);
    if (int'(x) < N) eff_sel = x;
    else             eff_sel = SELW'(N-1);
  endfunction

  logic [SELW-1:0] eff_rsel;
  logic [SELW-1:0] eff_wsel;
  logic [W-1:0]    cap_src;
  logic [W-1:0]    cap_data;
  logic            cap_fwd;

  assign eff_rsel = eff_sel(rsel);
  assign eff_wsel = eff_sel(wr_sel);

  // Source mux written as a compare loop so the select width never has to
  // match the index width of an array.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // it unassigned would infer a latch.
    cap_src = '0;
    for (int i = 0; i < N; i++) begin
      if (eff_rsel == SELW'(i)) cap_src = src[i*W +: W];
    end
  end

  // A write landing on the same edge as the read overrides the register file,
  // whose src view only reflects the write from the next edge onward.
  assign cap_fwd  = wr_en && (eff_wsel == eff_rsel);
  assign cap_data = cap_fwd ? wr_data : cap_src;

  // Stage state; index 0 is the capture stage, PIPE-1 drives the outputs.
  logic [PIPE-1:0] vld_q, vld_d;
  logic [PIPE-1:0] fwd_q, fwd_d;
  logic [SELW-1:0] sel_q [PIPE];
  logic [SELW-1:0] sel_d [PIPE];
  logic [W-1:0]    dat_q [PIPE];
  logic [W-1:0]    dat_d [PIPE];

  // Late-forwarded view of each stage: what the entry looks like once a write
  // landing on this edge has been applied. Used both for holding and for
  // advancing, so a forwarded value travels with its entry.
  logic [PIPE-1:0] lf_hit;
  logic [PIPE-1:0] lf_fwd;
  logic [W-1:0]    lf_dat [PIPE];

  always_comb begin
    for (int k = 0; k < PIPE; k++) begin
      lf_hit[k] = wr_en && vld_q[k] && (sel_q[k] == eff_wsel);
      lf_dat[k] = lf_hit[k] ? wr_data : dat_q[k];
      lf_fwd[k] = fwd_q[k] | lf_hit[k];
    end
  end

  always_comb begin
    vld_d = vld_q;
    fwd_d = fwd_q;
    sel_d = sel_q;
    dat_d = dat_q;
    if (cen) begin
      if (stall) begin
        // Hold: valid and select stay, only late forwarding applies.
        for (int k = 0; k < PIPE; k++) begin
          dat_d[k] = lf_dat[k];
          fwd_d[k] = lf_fwd[k];
        end
      end else begin
        if (rd_req) begin
          vld_d[0] = 1'b1;
          sel_d[0] = eff_rsel;
          dat_d[0] = cap_data;
          fwd_d[0] = cap_fwd;
        end else begin
          // Bubble: drop valid but keep the payload so the bus does not toggle.
          vld_d[0] = 1'b0;
          dat_d[0] = lf_dat[0];
          fwd_d[0] = lf_fwd[0];
        end
        for (int k = 1; k < PIPE; k++) begin
          vld_d[k] = vld_q[k-1];
          sel_d[k] = sel_q[k-1];
          dat_d[k] = lf_dat[k-1];
          fwd_d[k] = lf_fwd[k-1];
        end
      end
    end
  end

  // NOTE: the stage registers are few and reset is required to discard an
  // in-flight read, so the whole array is reset rather than just the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      fwd_q <= '0;
      for (int k = 0; k < PIPE; k++) begin
        sel_q[k] <= '0;
        dat_q[k] <= '0;
      end
    end else begin
      // NOTE: state uses non-blocking assignments so every stage samples the
      // pre-edge value of its predecessor.
      vld_q <= vld_d;
      fwd_q <= fwd_d;
      for (int k = 0; k < PIPE; k++) begin
        sel_q[k] <= sel_d[k];
        dat_q[k] <= dat_d[k];
      end
    end
  end

  assign rmux   = dat_q[PIPE-1];
  assign rvalid = vld_q[PIPE-1];
  assign rsel_q = sel_q[PIPE-1];
  assign fwd    = fwd_q[PIPE-1];

endmodule
